// File: rtl/puneh_arb_pkg.sv
// rtl/puneh_arb_pkg.sv - shared types and constants for the PUNEH memory arbiter
package puneh_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    localparam int DEF_AW      = 16;
    localparam int DEF_DW      = 16;
    localparam int DEF_TIMEOUT = 15;
    // Wide enough for the largest allowed TIMEOUT of 255.
    localparam int CNT_W       = 8;

endpackage

// File: rtl/puneh_mem_arbiter_if.sv
// rtl/puneh_mem_arbiter_if.sv - requester and memory-side signal bundle for the arbiter
interface puneh_mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          ack0;
    logic          ack1;
    logic          err0;
    logic          err1;
    logic [1:0]    gnt;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_rdata;
    logic          mem_rdy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_rdy,
        output rdata0, rdata1, ack0, ack1, err0, err1, gnt,
               mem_addr, mem_wdata, mem_read, mem_write
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_rdy,
        input  rdata0, rdata1, ack0, ack1, err0, err1, gnt,
               mem_addr, mem_wdata, mem_read, mem_write
    );

endinterface

// File: rtl/puneh_arb_pick.sv
// rtl/puneh_arb_pick.sv - combinational winner select; PUNEH_ARB_CPU_PRIO_EN selects fixed CPU priority
module puneh_arb_pick
    import puneh_arb_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_valid,
    output logic o_sel
);

    assign o_valid = i_req0 | i_req1;

`ifdef PUNEH_ARB_CPU_PRIO_EN
    logic w_unused_last;
    assign w_unused_last = i_last;

    assign o_sel = i_req0 ? REQ_CPU : REQ_DMA;
`else
    // On contention the requester not served last wins.
    always_comb begin
        o_sel = REQ_CPU;
        if (i_req0 && i_req1) begin
            o_sel = ~i_last;
        end else if (i_req1) begin
            o_sel = REQ_DMA;
        end
    end
`endif

endmodule

// File: rtl/puneh_mem_arbiter.sv
// rtl/puneh_mem_arbiter.sv - two-requester arbiter for the PUNEH 16-bit memory port
// Build option: PUNEH_ARB_CPU_PRIO_EN gives requester 0 fixed priority instead of round-robin.
module puneh_mem_arbiter
    import puneh_arb_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    puneh_mem_arbiter_if.slave   bus
);

    arb_state_t       r_state;
    arb_state_t       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last;
    logic [AW-1:0]    r_mem_addr;
    logic [DW-1:0]    r_mem_wdata;
    logic             r_mem_read;
    logic             r_mem_write;
    logic [1:0]       r_gnt;
    logic             r_ack0;
    logic             r_ack1;
    logic             r_err0;
    logic             r_err1;
    logic [DW-1:0]    r_rdata0;
    logic [DW-1:0]    r_rdata1;

    logic             w_pick_vld;
    logic             w_pick_sel;
    logic             w_sel_we;
    logic             w_owner;
    logic             w_done_ok;
    logic             w_tmo;

    puneh_arb_pick u_pick (
        .i_req0  (bus.req0),
        .i_req1  (bus.req1),
        .i_last  (r_last),
        .o_valid (w_pick_vld),
        .o_sel   (w_pick_sel)
    );

    assign w_sel_we  = w_pick_sel ? bus.we1 : bus.we0;
    assign w_owner   = r_gnt[1];
    assign w_done_ok = (r_state == ACCESS) && bus.mem_rdy;
    // Completion beats the timeout when both land in the same cycle.
    assign w_tmo     = (r_state == ACCESS) && !bus.mem_rdy && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_pick_vld) w_next = ACCESS;
            ACCESS:  if (w_done_ok || w_tmo) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_last      <= REQ_DMA;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_gnt       <= 2'b00;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_err0      <= 1'b0;
            r_err1      <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_pick_vld) begin
                        r_mem_addr  <= w_pick_sel ? bus.addr1 : bus.addr0;
                        r_mem_wdata <= w_pick_sel ? bus.wdata1 : bus.wdata0;
                        r_mem_read  <= ~w_sel_we;
                        r_mem_write <= w_sel_we;
                        r_gnt       <= w_pick_sel ? 2'b10 : 2'b01;
                    end
                end
                ACCESS: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_done_ok || w_tmo) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_last      <= w_owner;
                        if (w_owner) begin
                            r_ack1 <= 1'b1;
                            r_err1 <= w_tmo;
                        end else begin
                            r_ack0 <= 1'b1;
                            r_err0 <= w_tmo;
                        end
                        if (w_done_ok && r_mem_read) begin
                            if (w_owner) r_rdata1 <= bus.mem_rdata;
                            else         r_rdata0 <= bus.mem_rdata;
                        end
                    end
                end
                DONE: begin
                    r_cnt <= '0;
                    r_gnt <= 2'b00;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.gnt       = r_gnt;
    assign bus.ack0      = r_ack0;
    assign bus.ack1      = r_ack1;
    assign bus.err0      = r_err0;
    assign bus.err1      = r_err1;
    assign bus.rdata0    = r_rdata0;
    assign bus.rdata1    = r_rdata1;

endmodule

// File: tb/tb_puneh_mem_arbiter.sv
// tb/tb_puneh_mem_arbiter.sv - self-checking bench for puneh_mem_arbiter
module tb_puneh_mem_arbiter;

`ifdef PUNEH_ARB_CPU_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    typedef struct {
        logic        req0;
        logic        req1;
        logic        we0;
        logic        we1;
        logic [15:0] addr0;
        logic [15:0] addr1;
        logic [15:0] wdata0;
        logic [15:0] wdata1;
        int          dly;
        logic [15:0] mrd;
        int          own_rr;
        int          own_prio;
        logic        err;
        int          ncyc;
    } vec_t;

    typedef struct {
        int          own;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] mrd;
        int          dly;
        logic        err;
        int          ncyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    puneh_mem_arbiter_if #(.AW(16), .DW(16)) bus ();

    puneh_mem_arbiter #(.AW(16), .DW(16), .TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t        sbq[$];
    vec_t        vecs[7];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    bit          got_ack;
    int          strobe_cnt = 0;
    bit          stab_bad = 0;
    int          acc_cnt = 0;
    logic [15:0] m_rd[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // One cycle: check what the DUT shows at the negedge, then model the memory for this cycle.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        got_ack = 1'b0;
        if (bus.ack0 || bus.ack1) begin
            got_ack = 1'b1;
            if (sbq.size() == 0) begin
                chk("unexpected_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("ack_owner", {30'd0, bus.ack1, bus.ack0}, (e.own != 0) ? 32'd2 : 32'd1);
                chk("err", {30'd0, bus.err1, bus.err0}, e.err ? ((e.own != 0) ? 32'd2 : 32'd1) : 32'd0);
                chk("gnt_done", {30'd0, bus.gnt}, (e.own != 0) ? 32'd2 : 32'd1);
                if (!e.err && !e.we) m_rd[e.own] = e.mrd;
                chk("rdata_owner", {16'd0, (e.own != 0) ? bus.rdata1 : bus.rdata0}, {16'd0, m_rd[e.own]});
                chk("rdata_other", {16'd0, (e.own != 0) ? bus.rdata0 : bus.rdata1}, {16'd0, m_rd[1 - e.own]});
                chk("strobe_cycles", strobe_cnt, e.ncyc);
                chk("strobe_stable", {31'd0, stab_bad}, 32'd0);
            end
            strobe_cnt = 0;
            stab_bad   = 1'b0;
        end
        if (bus.mem_read || bus.mem_write) begin
            strobe_cnt++;
            if (sbq.size() == 0) begin
                stab_bad = 1'b1;
                bus.mem_rdy = 1'b0;
            end else begin
                e = sbq[0];
                if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.wdata ||
                    bus.mem_write !== e.we || bus.mem_read !== !e.we ||
                    bus.gnt !== ((e.own != 0) ? 2'b10 : 2'b01))
                    stab_bad = 1'b1;
                bus.mem_rdy = (acc_cnt == e.dly);
            end
            bus.mem_rdata = bus.mem_rdy ? sbq[0].mrd : 16'($urandom);
            acc_cnt++;
        end else begin
            bus.mem_rdy = 1'b0;
            acc_cnt = 0;
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        exp_t e;
        int   t0;
        bit   done;
        tick();
        bus.req0 = v.req0;  bus.req1 = v.req1;
        bus.we0 = v.we0;    bus.we1 = v.we1;
        bus.addr0 = v.addr0; bus.addr1 = v.addr1;
        bus.wdata0 = v.wdata0; bus.wdata1 = v.wdata1;
        e.own   = PRIO ? v.own_prio : v.own_rr;
        e.we    = (e.own != 0) ? v.we1 : v.we0;
        e.addr  = (e.own != 0) ? v.addr1 : v.addr0;
        e.wdata = (e.own != 0) ? v.wdata1 : v.wdata0;
        e.mrd   = v.mrd;
        e.dly   = v.dly;
        e.err   = v.err;
        e.ncyc  = v.ncyc;
        sbq.push_back(e);
        t0 = cyc;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            tick();
            if (got_ack) done = 1'b1;
            else begin
                // Address/data are only meaningful in the sampling cycle.
                bus.addr0 = 16'($urandom); bus.addr1 = 16'($urandom);
                bus.wdata0 = 16'($urandom); bus.wdata1 = 16'($urandom);
            end
        end
        chk({name, "_ack_seen"}, {31'd0, done}, 32'd1);
        if (done) chk({name, "_ack_latency"}, cyc - t0, e.ncyc + 1);
        else sbq.delete();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        vec_t vr;
        int   n_ack;
        int   ack_cyc[4];

        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
        bus.mem_rdata = 0; bus.mem_rdy = 0;
        m_rd[0] = 16'h0; m_rd[1] = 16'h0;

        // req0 req1 we0 we1 addr0 addr1 wdata0 wdata1 dly mrd own_rr own_prio err ncyc
        vecs[0] = '{1, 0, 0, 0, 16'h0040, 16'h0000, 16'h0000, 16'h0000,   0, 16'hBEEF, 0, 0, 0,  1};
        vecs[1] = '{0, 1, 0, 1, 16'h0000, 16'h1234, 16'h0000, 16'h00FF,   3, 16'hDEAD, 1, 1, 0,  4};
        vecs[2] = '{1, 1, 0, 0, 16'h0100, 16'h0200, 16'hAAAA, 16'h5555,   1, 16'h1111, 0, 0, 0,  2};
        vecs[3] = '{1, 1, 0, 0, 16'h0101, 16'h0201, 16'h0000, 16'h0000,   0, 16'h2222, 1, 0, 0,  1};
        vecs[4] = '{1, 0, 0, 0, 16'h0042, 16'h0000, 16'h0000, 16'h0000, 255, 16'hFFFF, 0, 0, 1, 15};
        vecs[5] = '{1, 0, 0, 0, 16'h0044, 16'h0000, 16'h0000, 16'h0000,  14, 16'h5A5A, 0, 0, 0, 15};
        vecs[6] = '{1, 1, 1, 1, 16'h0600, 16'h0700, 16'h1357, 16'h2468,   2, 16'h0000, 1, 0, 0,  3};

        repeat (2) @(negedge clk);
        chk("rst_gnt", {30'd0, bus.gnt}, 32'd0);
        chk("rst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        chk("rst_ack_err", {28'd0, bus.ack0, bus.ack1, bus.err0, bus.err1}, 32'd0);
        chk("rst_rdata", {bus.rdata1, bus.rdata0}, 32'd0);
        chk("rst_mem_bus", {bus.mem_addr, bus.mem_wdata}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Continuous contention: requests held through several accesses.
        tick();
        bus.req0 = 1; bus.req1 = 1; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = 16'h0300; bus.addr1 = 16'h0400;
        bus.wdata0 = 16'h0303; bus.wdata1 = 16'h0404;
        for (int i = 0; i < 4; i++) begin
            e.own   = PRIO ? 0 : (i % 2);
            e.we    = 1'b0;
            e.addr  = (e.own != 0) ? 16'h0400 : 16'h0300;
            e.wdata = (e.own != 0) ? 16'h0404 : 16'h0303;
            e.mrd   = 16'(16'hC000 + i);
            e.dly   = 0;
            e.err   = 1'b0;
            e.ncyc  = 1;
            sbq.push_back(e);
        end
        n_ack = 0;
        for (int i = 0; i < 100 && n_ack < 4; i++) begin
            tick();
            if (got_ack) begin
                ack_cyc[n_ack] = cyc;
                n_ack++;
            end
        end
        chk("contention_acks", n_ack, 4);
        for (int i = 1; i < 4; i++)
            if (n_ack > i) chk("ack_spacing", ack_cyc[i] - ack_cyc[i-1], 3);
        bus.req0 = 0; bus.req1 = 0;
        sbq.delete();

        // Asynchronous reset in the middle of a stalled read.
        tick();
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0500; bus.wdata0 = 16'h0000;
        e.own = 0; e.we = 1'b0; e.addr = 16'h0500; e.wdata = 16'h0000;
        e.mrd = 16'h9999; e.dly = 1000; e.err = 1'b0; e.ncyc = 0;
        sbq.push_back(e);
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        chk("arst_gnt", {30'd0, bus.gnt}, 32'd0);
        bus.req0 = 0;
        bus.mem_rdy = 0;
        sbq.delete();
        strobe_cnt = 0; stab_bad = 1'b0; acc_cnt = 0;
        m_rd[0] = 16'h0; m_rd[1] = 16'h0;
        repeat (3) @(negedge clk);
        chk("arst_no_ack", {28'd0, bus.ack0, bus.ack1, bus.err0, bus.err1}, 32'd0);
        rst = 1'b0;
        vr = '{0, 1, 0, 0, 16'h0000, 16'h0ABC, 16'h0000, 16'h0000, 1, 16'h7777, 1, 1, 0, 2};
        run_vec(vr, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
